// File: rtl/ftdi_pkg.sv
// Shared types and default timing for the FT245-style transmit bridge.
// Write-strobe timing defaults are in clk_i cycles.
package ftdi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold,
      StRecover
   } tx_state_e;

   localparam int unsigned DEF_WR_SETUP    = 2;
   localparam int unsigned DEF_WR_PULSE    = 3;
   localparam int unsigned DEF_WR_HOLD     = 1;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   localparam int unsigned DROP_CNT_W = 16;
   // Wide enough for any of the phase lengths above.
   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/ftdi_tx_fifo.sv
// Single-clock FIFO with a show-ahead head output and a registered occupancy level.
// The caller never pushes when full without a pop, and never pops when empty.
module ftdi_tx_fifo
   import ftdi_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned AW     = 4
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       level_q, level_d;

   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // Storage is not reset; pointer reset alone discards the contents.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (level_q == (AW+1)'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;

endmodule

// File: rtl/ftdi_tx_bridge.sv
// Buffers pulsed bytes and drains them to an FT245-style asynchronous FIFO write port,
// counting bytes dropped while the buffer is full.
module ftdi_tx_bridge
   import ftdi_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned FIFO_AW     = 4,
   parameter int unsigned WR_SETUP    = DEF_WR_SETUP,
   parameter int unsigned WR_PULSE    = DEF_WR_PULSE,
   parameter int unsigned WR_HOLD     = DEF_WR_HOLD,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  data_in_pulse,
   input  logic                  ftdi_txe_n,
   output logic                  ftdi_wr_n,
   output logic [DATA_W-1:0]     ftdi_data_o,
   output logic                  ftdi_data_oe,
   output logic [FIFO_AW:0]      fifo_level,
   output logic                  overflow_pulse,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   tx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                  wr_n_q, wr_n_d;
   logic                  oe_q, oe_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  ovf_q;
   logic [DROP_CNT_W-1:0] drop_q;

   logic              txe_ok, push, pop, drop;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   assign txe_ok = ~sync_q[SYNC_STAGES-1];
   assign pop    = (state_q == StIdle) && !fifo_empty && txe_ok;
   assign push   = data_in_pulse && (!fifo_full || pop);
   assign drop   = data_in_pulse && fifo_full && !pop;

   ftdi_tx_fifo #(
      .DATA_W (DATA_W),
      .AW     (FIFO_AW)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (data_in),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sync_q  <= '1;
         wr_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ftdi_txe_n};
         wr_n_q  <= wr_n_d;
         oe_q    <= oe_d;
         data_q  <= data_d;
         ovf_q   <= drop;
         if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
   end

   // Once a byte is popped the write sequence runs to completion regardless of txe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = StSetup;
               cnt_d   = CNT_W'(WR_SETUP - 1);
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StStrobe;
               cnt_d   = CNT_W'(WR_PULSE - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StStrobe: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               cnt_d   = CNT_W'(WR_HOLD - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StRecover;
               cnt_d   = CNT_W'(SYNC_STAGES);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StRecover: begin
            // Lets a txe_n rise caused by this write reach the synchronizer output.
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so wr_n and oe never glitch.
   always_comb begin
      wr_n_d = (state_d != StStrobe);
      oe_d   = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
      data_d = pop ? fifo_head : data_q;
   end

   assign ftdi_wr_n      = wr_n_q;
   assign ftdi_data_oe   = oe_q;
   assign ftdi_data_o    = data_q;
   assign overflow_pulse = ovf_q;
   assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_ftdi_tx_bridge.sv
// Self-checking bench for ftdi_tx_bridge: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based transaction model.
module tb_ftdi_tx_bridge;

   localparam int DATA_W      = 8;
   localparam int FIFO_AW     = 4;
   localparam int DEPTH       = 16;
   localparam int WR_SETUP    = 2;
   localparam int WR_PULSE    = 3;
   localparam int WR_HOLD     = 1;
   localparam int SYNC_STAGES = 2;
   localparam int OE_CYC      = WR_SETUP + WR_PULSE + WR_HOLD;
   localparam int PERIOD      = 1 + OE_CYC + SYNC_STAGES + 1;

   logic              clk_i = 1'b0;
   logic              rst_n = 1'b1;
   logic [DATA_W-1:0] data_in = '0;
   logic              data_in_pulse = 1'b0;
   logic              ftdi_txe_n = 1'b1;
   logic              ftdi_wr_n;
   logic [DATA_W-1:0] ftdi_data_o;
   logic              ftdi_data_oe;
   logic [FIFO_AW:0]  fifo_level;
   logic              overflow_pulse;
   logic [15:0]       drop_cnt;

   always #5 clk_i = ~clk_i;

   ftdi_tx_bridge #(
      .DATA_W      (DATA_W),
      .FIFO_AW     (FIFO_AW),
      .WR_SETUP    (WR_SETUP),
      .WR_PULSE    (WR_PULSE),
      .WR_HOLD     (WR_HOLD),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_i          (clk_i),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .data_in_pulse  (data_in_pulse),
      .ftdi_txe_n     (ftdi_txe_n),
      .ftdi_wr_n      (ftdi_wr_n),
      .ftdi_data_o    (ftdi_data_o),
      .ftdi_data_oe   (ftdi_data_oe),
      .fifo_level     (fifo_level),
      .overflow_pulse (overflow_pulse),
      .drop_cnt       (drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction model: byte queue, pop every PERIOD edges at most, txe seen SYNC_STAGES late.
   logic [7:0] m_fifo[$];
   logic [7:0] m_popped[$];
   bit         m_txe_hist[$];
   int         m_edge, m_last_pop, m_drop;
   bit         m_ovf;
   logic [7:0] m_data;

   always @(posedge clk_i or negedge rst_n) begin : p_model
      bit ok;
      if (!rst_n) begin
         m_fifo.delete();
         m_txe_hist.delete();
         for (int i = 0; i < SYNC_STAGES; i++) m_txe_hist.push_back(1'b1);
         m_edge     = 0;
         m_last_pop = -1000;
         m_drop     = 0;
         m_ovf      = 1'b0;
         m_data     = '0;
      end else begin
         ok = !m_txe_hist.pop_front();
         m_txe_hist.push_back(ftdi_txe_n);
         m_edge++;
         if ((m_edge - m_last_pop >= PERIOD) && (m_fifo.size() > 0) && ok) begin
            m_data     = m_fifo.pop_front();
            m_last_pop = m_edge;
            m_popped.push_back(m_data);
         end
         m_ovf = 1'b0;
         if (data_in_pulse) begin
            if (m_fifo.size() < DEPTH) begin
               m_fifo.push_back(data_in);
            end else begin
               m_ovf = 1'b1;
               if (m_drop < 65535) m_drop++;
            end
         end
      end
   end

   always @(negedge clk_i) begin : p_check
      int d;
      if (rst_n) begin
         d = m_edge - m_last_pop;
         check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
         check("ftdi_data_oe", 32'(ftdi_data_oe), 32'(d < OE_CYC));
         check("ftdi_wr_n", 32'(ftdi_wr_n), 32'(!(d >= WR_SETUP && d < WR_SETUP + WR_PULSE)));
         check("ftdi_data_o", 32'(ftdi_data_o), 32'(m_data));
         check("overflow_pulse", 32'(overflow_pulse), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      end
   end

   // Write log captured at each falling edge of wr_n, independent of the model.
   logic [7:0] wr_log[$];
   logic       prev_wr_n = 1'b1;
   int         cyc = 0;
   int         last_wr = -1000;
   int         ovf_seen = 0;

   always @(negedge clk_i) begin
      cyc++;
      if (rst_n && prev_wr_n && !ftdi_wr_n) begin
         wr_log.push_back(ftdi_data_o);
         check("wr_spacing", 32'(cyc - last_wr >= PERIOD), 32'd1);
         last_wr = cyc;
      end
      if (rst_n && overflow_pulse) ovf_seen++;
      prev_wr_n = ftdi_wr_n;
   end

   task automatic step(input bit p, input logic [7:0] d);
      @(negedge clk_i);
      #1;
      data_in_pulse = p;
      data_in       = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic wait_wr_low(input string tag);
      int n;
      n = 0;
      while (ftdi_wr_n !== 1'b0 && n < 50) begin
         step(1'b0, 8'h00);
         n++;
      end
      check(tag, 32'(n < 50), 32'd1);
   endtask

   task automatic expect_log(input string tag, input logic [7:0] first, input int n);
      check({tag, "_count"}, 32'(wr_log.size()), 32'(n));
      for (int i = 0; i < n && i < wr_log.size(); i++) begin
         check({tag, "_byte"}, 32'(wr_log[i]), 32'(8'(first + 8'(i))));
      end
      wr_log.delete();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;

      // Reset then idle with the host not ready.
      idle(100);
      check("idle_no_writes", 32'(wr_log.size()), 32'd0);

      // Single byte.
      ftdi_txe_n = 1'b0;
      idle(5);
      step(1'b1, 8'hA5);
      idle(20);
      expect_log("single", 8'hA5, 1);

      // Back-pressure and ordering.
      ftdi_txe_n = 1'b1;
      idle(3);
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
      idle(10);
      check("bp_level", 32'(fifo_level), 32'd5);
      check("bp_no_writes", 32'(wr_log.size()), 32'd0);
      ftdi_txe_n = 1'b0;
      idle(80);
      expect_log("bp", 8'h01, 5);

      // Overflow.
      ftdi_txe_n = 1'b1;
      idle(3);
      ovf_seen = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h10 + i));
      idle(3);
      check("ovf_level", 32'(fifo_level), 32'd16);
      check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
      check("ovf_pulses", 32'(ovf_seen), 32'd4);
      ftdi_txe_n = 1'b0;
      idle(200);
      expect_log("ovf", 8'h10, 16);

      // txe_n rises during the strobe: current byte completes, next waits.
      step(1'b1, 8'h40);
      step(1'b1, 8'h41);
      wait_wr_low("mid_txe_wait");
      ftdi_txe_n = 1'b1;
      idle(40);
      check("mid_txe_one_write", 32'(wr_log.size()), 32'd1);
      check("mid_txe_level", 32'(fifo_level), 32'd1);
      ftdi_txe_n = 1'b0;
      idle(40);
      expect_log("mid_txe", 8'h40, 2);

      // Reset during the strobe.
      step(1'b1, 8'h50);
      step(1'b1, 8'h51);
      wait_wr_low("rst_wait");
      rst_n = 1'b0;
      #1;
      check("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
      check("rst_oe", 32'(ftdi_data_oe), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      idle(2);
      rst_n = 1'b1;
      wr_log.delete();
      idle(5);
      step(1'b1, 8'h3C);
      idle(30);
      expect_log("post_rst", 8'h3C, 1);

      // Random traffic with toggling back-pressure.
      m_popped.delete();
      wr_log.delete();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) == 0), 8'($urandom));
         if ($urandom_range(0, 39) == 0) ftdi_txe_n = ~ftdi_txe_n;
      end
      ftdi_txe_n = 1'b0;
      idle(250);
      check("rand_drained", 32'(fifo_level), 32'd0);
      check("rand_count", 32'(wr_log.size()), 32'(m_popped.size()));
      for (int i = 0; i < wr_log.size() && i < m_popped.size(); i++) begin
         check("rand_byte", 32'(wr_log[i]), 32'(m_popped[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
